// File: rtl/prime_pkg.sv
// -----------------------------------------------------------------------------
// prime_pkg
// Shared definitions for the prime-unit arbiter:
//   state_t         four-state controller encoding (IDLE, ISSUE, WAIT, RESP)
//   NUM_REQ_DEF     default number of requesters
//   DATA_W_DEF      default operand width (matches the prime unit)
//   TIMEOUT_DEF     default watchdog limit in cycles (PRIME_ARB_TIMEOUT_EN builds)
// -----------------------------------------------------------------------------
package prime_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 4;
   localparam int TIMEOUT_DEF = 64;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. The search begins at requester 'ptr' and
// wraps modulo NUM_REQ; the first active request found wins.
//   req  in   NUM_REQ  request vector
//   ptr  in   PTR_W    index of the highest-priority requester (< NUM_REQ)
//   gnt  out  NUM_REQ  one-hot winner, zero when no request is active
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic found;
   int   idx;

   // Outer loop walks priority offsets, inner loop keeps every bit select
   // constant so the picker unrolls into plain compare/mux logic.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req[j] && (j == idx)) begin
               gnt[j] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/prime_arbiter.sv
// -----------------------------------------------------------------------------
// prime_arbiter
// Shares one prime unit among NUM_REQ requesters. A round-robin winner is
// chosen in IDLE, its operand latched, the unit started (ISSUE), its result
// awaited (WAIT) and returned with a one-cycle done pulse (RESP).
//
// Optional feature macro: PRIME_ARB_TIMEOUT_EN
//   defined   - watchdog counts ISSUE/WAIT cycles; at TIMEOUT the operation is
//               forced to RESP with res_prime_o=0 and error_o pulsing.
//   undefined - no watchdog, error_o tied low, ISSUE/WAIT wait indefinitely.
//
// Ports:
//   clk            in   1                 system clock, rising edge
//   rst_n          in   1                 asynchronous active-low reset
//   req_i          in   NUM_REQ           per-requester request level
//   data_i         in   NUM_REQ*DATA_W    operands, requester k at [k*DATA_W +: DATA_W]
//   gnt_o          out  NUM_REQ           one-hot grant, ISSUE through RESP
//   done_o         out  NUM_REQ           one-cycle completion pulse
//   res_prime_o    out  1                 result, valid with done_o
//   error_o        out  1                 timeout flag, pulses with done_o
//   busy_o         out  1                 controller not in IDLE
//   prime_en_o     out  1                 prime unit enable
//   prime_data_o   out  DATA_W            prime unit operand
//   prime_valid_i  in   1                 prime unit idle/done indication
//   prime_prime_i  in   1                 prime unit result
// -----------------------------------------------------------------------------
module prime_arbiter
   import prime_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic                      res_prime_o,
   output logic                      error_o,
   output logic                      busy_o,
   output logic                      prime_en_o,
   output logic [DATA_W-1:0]         prime_data_o,
   input  logic                      prime_valid_i,
   input  logic                      prime_prime_i
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("prime_arbiter: NUM_REQ must be at least 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("prime_arbiter: TIMEOUT must be at least 1");
   end

   state_t              state;
   logic [NUM_REQ-1:0]  gnt;
   logic [NUM_REQ-1:0]  done;
   logic [NUM_REQ-1:0]  pick;
   logic [PTR_W-1:0]    ptr;
   logic [PTR_W-1:0]    widx;
   logic [PTR_W-1:0]    pick_idx;
   logic [DATA_W-1:0]   pick_data;
   logic [DATA_W-1:0]   pdata;
   logic                res;
   logic                en;
   logic                timeout;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
   endfunction

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .req (req_i),
      .ptr (ptr),
      .gnt (pick)
   );

   // Index and operand of the current winner.
   always_comb begin
      pick_idx  = '0;
      pick_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (pick[j]) begin
            pick_idx  = PTR_W'(j);
            pick_data = data_i[j*DATA_W +: DATA_W];
         end
      end
   end

`ifdef PRIME_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt;
   logic             err;

   // Counter is cleared in IDLE so it reads 0 on the first ISSUE cycle;
   // the expiry edge is therefore exactly TIMEOUT cycles after ISSUE entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         err <= 1'b0;
      end else begin
         if (state == IDLE)
            cnt <= '0;
         else if ((state == ISSUE) || (state == WAIT))
            cnt <= cnt + 1'b1;
         err <= ((state == ISSUE) || (state == WAIT)) && timeout;
      end
   end

   assign timeout = (cnt == CNT_W'(TIMEOUT - 1));
   assign error_o = err;
`else
   assign timeout = 1'b0;
   assign error_o = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         gnt   <= '0;
         done  <= '0;
         res   <= 1'b0;
         en    <= 1'b0;
         pdata <= '0;
         ptr   <= '0;
         widx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if ((|req_i) && prime_valid_i) begin
                  gnt   <= pick;
                  widx  <= pick_idx;
                  pdata <= pick_data;
                  en    <= 1'b1;
                  state <= ISSUE;
               end
            end
            ISSUE: begin
               if (timeout) begin
                  en    <= 1'b0;
                  res   <= 1'b0;
                  done  <= gnt;
                  state <= RESP;
               end else if (!prime_valid_i) begin
                  // Unit has accepted the operand and is computing.
                  en    <= 1'b0;
                  state <= WAIT;
               end
            end
            WAIT: begin
               if (timeout) begin
                  res   <= 1'b0;
                  done  <= gnt;
                  state <= RESP;
               end else if (prime_valid_i) begin
                  res   <= prime_prime_i;
                  done  <= gnt;
                  state <= RESP;
               end
            end
            RESP: begin
               // Served requester drops to lowest priority.
               done  <= '0;
               gnt   <= '0;
               ptr   <= next_ptr(widx);
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign gnt_o        = gnt;
   assign done_o       = done;
   assign res_prime_o  = res;
   assign busy_o       = (state != IDLE);
   assign prime_en_o   = en;
   assign prime_data_o = pdata;

endmodule

// File: tb/tb_prime_arbiter.sv
`timescale 1ns/1ps
module tb_prime_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 4;
   localparam int TIMEOUT = 64;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic [NUM_REQ-1:0]        req_i = '0;
   logic [NUM_REQ*DATA_W-1:0] data_i = '0;
   logic [NUM_REQ-1:0]        gnt_o;
   logic [NUM_REQ-1:0]        done_o;
   logic                      res_prime_o;
   logic                      error_o;
   logic                      busy_o;
   logic                      prime_en_o;
   logic [DATA_W-1:0]         prime_data_o;
   logic                      prime_valid_i;
   logic                      prime_prime_i;

   typedef struct packed {
      logic [NUM_REQ-1:0] done;
      logic               res;
      logic               err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic stuck = 1'b0;

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prime_arbiter #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_i         (req_i),
      .data_i        (data_i),
      .gnt_o         (gnt_o),
      .done_o        (done_o),
      .res_prime_o   (res_prime_o),
      .error_o       (error_o),
      .busy_o        (busy_o),
      .prime_en_o    (prime_en_o),
      .prime_data_o  (prime_data_o),
      .prime_valid_i (prime_valid_i),
      .prime_prime_i (prime_prime_i)
   );

   // Prime unit: valid while idle, drops for 4 cycles once started, then
   // presents the primality of the latched operand. 'stuck' holds it idle.
   logic [DATA_W-1:0] pu_op;
   logic [2:0]        pu_cnt;

   function automatic logic is_prime(input logic [DATA_W-1:0] v);
      if (v < 2) return 1'b0;
      for (int d = 2; d < 16; d++)
         if ((d < int'(v)) && ((int'(v) % d) == 0)) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prime_valid_i <= 1'b1;
         prime_prime_i <= 1'b0;
         pu_op         <= '0;
         pu_cnt        <= '0;
      end else if (stuck) begin
         prime_valid_i <= 1'b1;
      end else if (prime_valid_i) begin
         if (prime_en_o) begin
            prime_valid_i <= 1'b0;
            pu_op         <= prime_data_o;
            pu_cnt        <= 3'd3;
         end
      end else if (pu_cnt == 0) begin
         prime_valid_i <= 1'b1;
         prime_prime_i <= is_prime(pu_op);
      end else begin
         pu_cnt <= pu_cnt - 1'b1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [NUM_REQ-1:0] d, input logic r, input logic e);
      exp_t t;
      t.done = d;
      t.res  = r;
      t.err  = e;
      exp_q.push_back(t);
   endtask

   task automatic set_data(input int k, input logic [DATA_W-1:0] v);
      data_i[k*DATA_W +: DATA_W] = v;
   endtask

   // Scoreboard monitor: invariants every cycle, expectation popped per done.
   always @(negedge clk) begin
      if (rst_n) begin
         check("onehot_gnt_done", {30'b0, $onehot0(gnt_o), $onehot0(done_o)}, 32'h3);
         if (done_o != '0) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=%b with nothing expected (t=%0t)", done_o, $time);
            end else begin
               mon_e = exp_q.pop_front();
               check("done_vec", 32'(done_o), 32'(mon_e.done));
               check("res_prime", 32'(res_prime_o), 32'(mon_e.res));
               check("error", 32'(error_o), 32'(mon_e.err));
               check("gnt_eq_done", 32'(gnt_o), 32'(done_o));
            end
         end
      end
   end

   task automatic wait_dones(input int n, input bit clear, input int budget);
      int seen = 0;
      int k = 0;
      while ((seen < n) && (k < budget)) begin
         @(negedge clk);
         k++;
         if (done_o != '0) begin
            seen++;
            if (clear) req_i = req_i & ~done_o;
         end
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL wait_dones_timeout: got %0d dones, expected %0d", seen, n);
      end
   endtask

   task automatic wait_wait_state(input int budget);
      int k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(busy_o && !prime_en_o && (done_o == '0)) && (k < budget));
      if (k >= budget) begin
         checks++;
         errors++;
         $display("FAIL wait_state_timeout: got busy=%b en=%b, expected WAIT", busy_o, prime_en_o);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   32'(gnt_o), 32'h0);
      check({tag, "_done"},  32'(done_o), 32'h0);
      check({tag, "_res"},   32'(res_prime_o), 32'h0);
      check({tag, "_err"},   32'(error_o), 32'h0);
      check({tag, "_busy"},  32'(busy_o), 32'h0);
      check({tag, "_en"},    32'(prime_en_o), 32'h0);
      check({tag, "_pdata"}, 32'(prime_data_o), 32'h0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL global_watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #5;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Single requester: 2 is prime, 6 is not
      set_data(0, 4'd2);
      push(4'b0001, 1'b1, 1'b0);
      req_i = 4'b0001;
      wait_dones(1, 1'b1, 100);
      set_data(0, 4'd6);
      push(4'b0001, 1'b0, 1'b0);
      req_i = 4'b0001;
      wait_dones(1, 1'b1, 100);

      // All four at once from a fresh pointer: order 0,1,2,3
      apply_reset();
      set_data(0, 4'd3);
      set_data(1, 4'd6);
      set_data(2, 4'd13);
      set_data(3, 4'd15);
      push(4'b0001, 1'b1, 1'b0);
      push(4'b0010, 1'b0, 1'b0);
      push(4'b0100, 1'b1, 1'b0);
      push(4'b1000, 1'b0, 1'b0);
      req_i = 4'b1111;
      wait_dones(4, 1'b1, 300);

      // Requesters 0 and 2 held high: alternate 0,2,0,2
      set_data(0, 4'd5);
      set_data(2, 4'd9);
      push(4'b0001, 1'b1, 1'b0);
      push(4'b0100, 1'b0, 1'b0);
      push(4'b0001, 1'b1, 1'b0);
      push(4'b0100, 1'b0, 1'b0);
      req_i = 4'b0101;
      wait_dones(4, 1'b0, 300);
      req_i = 4'b0000;

      // Withdrawal and operand change during WAIT do not abort
      set_data(1, 4'd7);
      push(4'b0010, 1'b1, 1'b0);
      req_i = 4'b0010;
      wait_wait_state(50);
      req_i = 4'b0000;
      set_data(1, 4'd4);
      wait_dones(1, 1'b0, 100);

      // Reset during WAIT: silent discard, pointer back to 0
      set_data(2, 4'd11);
      req_i = 4'b0100;
      wait_wait_state(50);
      #5;
      rst_n = 1'b0;
      req_i = 4'b0000;
      #1;
      check_all_zero("midreset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("no_done_after_reset", 32'(exp_q.size()), 32'h0);
      set_data(1, 4'd4);
      set_data(2, 4'd11);
      push(4'b0010, 1'b0, 1'b0);
      push(4'b0100, 1'b1, 1'b0);
      req_i = 4'b0110;
      wait_dones(2, 1'b1, 200);

`ifdef PRIME_ARB_TIMEOUT_EN
      // Watchdog: unit never starts, forced completion after TIMEOUT cycles
      begin
         int t0;
         int k;
         stuck = 1'b1;
         set_data(0, 4'd2);
         push(4'b0001, 1'b0, 1'b1);
         req_i = 4'b0001;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while (!prime_en_o && (k < 20));
         t0 = cyc;
         req_i = 4'b0000;
         k = 0;
         do begin
            @(negedge clk);
            k++;
         end while ((done_o == '0) && (k < 200));
         check("timeout_latency", 32'(cyc - t0), 32'(TIMEOUT));
         stuck = 1'b0;
      end
`endif

      repeat (5) @(negedge clk);
      check("queue_empty", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
